// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: store-side bus controller; aligns SB/SH/SW into one or two
// word-aligned byte-enabled writes and stalls the core through oReady.
module mem_store_ctrl #(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iValid,
    output logic        oReady,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddress,
    input  logic [31:0] iData,
    output logic        oMemWrite,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic [3:0]  oMemByteEn,
    input  logic        iMemAck,
    output logic        oDone,
    output logic        oError
);
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_base;
    logic [7:0]  r_m8;
    logic [63:0] r_d64;
    logic [15:0] r_cnt;
    logic        r_done;
    logic [1:0]  w_off;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic        w_ready, w_busy, w_accept, w_illegal, w_split, w_timeout, w_done;

    always_comb begin
        w_off     = iAddress[1:0];
        w_mask    = iFunct3 == F3_SB ? 4'b0001 : iFunct3 == F3_SH ? 4'b0011 : 4'b1111;
        w_wdata   = iData & {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
        w_illegal = !(iFunct3 == F3_SB || iFunct3 == F3_SH || iFunct3 == F3_SW) ||
                    (!ALLOW_MISALIGNED && ((iFunct3 == F3_SH && w_off[0]) || (iFunct3 == F3_SW && w_off != 2'b00)));
        w_ready   = r_state == IDLE || r_state == ERR;
        w_busy    = r_state == BEAT0 || r_state == BEAT1;
        w_accept  = iValid && w_ready;
        w_split   = r_m8[7:4] != 4'b0000;
        // Counter holds the number of cycles already spent waiting in this beat
        w_timeout = TIMEOUT_CYCLES != 0 && w_busy && !iMemAck && r_cnt == 16'(TIMEOUT_CYCLES - 1);
        w_next    = r_state;
        w_done    = 1'b0;
        case (r_state)
            BEAT0: begin
                if (iMemAck) begin
                    w_next = w_split ? BEAT1 : IDLE;
                    w_done = !w_split;
                end else if (w_timeout) w_next = ERR;
            end
            BEAT1: begin
                if (iMemAck) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end else if (w_timeout) w_next = ERR;
            end
            default: w_next = w_accept ? (w_illegal ? ERR : BEAT0) : IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_m8    <= '0;
            r_d64   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done;
            r_cnt   <= w_next != r_state ? 16'd0 : r_cnt + 16'd1;
            if (w_accept) begin
                r_base <= {iAddress[31:2], 2'b00};
                r_m8   <= {4'b0000, w_mask} << w_off;
                r_d64  <= {32'b0, w_wdata} << {w_off, 3'b000};
            end
        end
    end

    assign oReady     = w_ready;
    assign oMemWrite  = w_busy;
    assign oMemAddr   = r_state == BEAT1 ? r_base + 32'd4 : r_state == BEAT0 ? r_base : 32'd0;
    assign oMemByteEn = r_state == BEAT1 ? r_m8[7:4] : r_state == BEAT0 ? r_m8[3:0] : 4'd0;
    assign oMemWData  = r_state == BEAT1 ? r_d64[63:32] : r_state == BEAT0 ? r_d64[31:0] : 32'd0;
    assign oDone      = r_done;
    assign oError     = r_state == ERR;
endmodule

// File: tb/tb_mem_store_ctrl.sv
// tb_mem_store_ctrl: scoreboard bench for mem_store_ctrl; a byte-wise model
// predicts each bus beat, the monitor pops and compares on every acked beat.
module tb_mem_store_ctrl;
    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } beat_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid = 1'b0, ack = 1'b1;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0, data = '0;
    logic        ready, mw, done, err;
    logic [31:0] maddr, mwdata;
    logic [3:0]  mbe;

    logic        valid2 = 1'b0;
    logic [2:0]  f3_2 = '0;
    logic [31:0] addr2 = '0, data2 = '0;
    logic        ready2, mw2, done2, err2;
    logic [31:0] maddr2, mwdata2;
    logic [3:0]  mbe2;

    beat_t exp_q[$];
    int    n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_store_ctrl #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(4)) dut (
        .iCLK(clk), .iRST_n(rst_n), .iValid(valid), .oReady(ready), .iFunct3(f3),
        .iAddress(addr), .iData(data), .oMemWrite(mw), .oMemAddr(maddr),
        .oMemWData(mwdata), .oMemByteEn(mbe), .iMemAck(ack), .oDone(done), .oError(err));

    mem_store_ctrl #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(4)) dut_na (
        .iCLK(clk), .iRST_n(rst_n), .iValid(valid2), .oReady(ready2), .iFunct3(f3_2),
        .iAddress(addr2), .iData(data2), .oMemWrite(mw2), .oMemAddr(maddr2),
        .oMemWData(mwdata2), .oMemByteEn(mbe2), .iMemAck(1'b1), .oDone(done2), .oError(err2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Places each stored byte at its own byte address, then groups by word
    function automatic void model(input logic [2:0] fn, input logic [31:0] a, d,
                                  output beat_t b0, output beat_t b1);
        int n;
        logic [31:0] ba;
        n  = fn == 3'b000 ? 1 : fn == 3'b001 ? 2 : 4;
        b0 = '0;
        b1 = '0;
        b0.a = {a[31:2], 2'b00};
        b1.a = b0.a + 32'd4;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            if ({ba[31:2], 2'b00} == b0.a) begin
                b0.be[ba[1:0]] = 1'b1;
                b0.d[int'(ba[1:0]) * 8 +: 8] = d[i * 8 +: 8];
            end else begin
                b1.be[ba[1:0]] = 1'b1;
                b1.d[int'(ba[1:0]) * 8 +: 8] = d[i * 8 +: 8];
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && mw && ack) begin
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_addr", 64'(maddr), 64'(e.a));
                chk("beat_be", 64'(mbe), 64'(e.be));
                chk("beat_data", 64'(mwdata), 64'(e.d));
            end
        end
    end

    task automatic do_store(input string tag, input logic [2:0] fn, input logic [31:0] a, d,
                            input bit push, input int exp_lat, input int exp_mw, input bit exp_err);
        beat_t b0, b1;
        int lat = 0, mwc = 0;
        model(fn, a, d, b0, b1);
        if (push) begin
            exp_q.push_back(b0);
            if (b1.be != 4'd0) exp_q.push_back(b1);
        end
        @(posedge clk); #1;
        valid = 1'b1; f3 = fn; addr = a; data = d;
        @(posedge clk); #1;
        valid = 1'b0; f3 = $urandom_range(7, 0); addr = $urandom; data = $urandom;
        for (int k = 0; k < 40; k++) begin
            if (mw) mwc++;
            if (done || err) break;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_write_cycles"}, 64'(mwc), 64'(exp_mw));
        chk({tag, "_done"}, 64'(done), 64'(!exp_err));
        chk({tag, "_error"}, 64'(err), 64'(exp_err));
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, 64'(done | err), 64'd0);
    endtask

    task automatic st2(input string tag, input logic [2:0] fn, input logic [31:0] a, d, input bit exp_err);
        beat_t b0, b1;
        model(fn, a, d, b0, b1);
        @(posedge clk); #1;
        valid2 = 1'b1; f3_2 = fn; addr2 = a; data2 = d;
        @(posedge clk); #1;
        valid2 = 1'b0;
        chk({tag, "_error"}, 64'(err2), 64'(exp_err));
        chk({tag, "_write"}, 64'(mw2), 64'(!exp_err));
        if (!exp_err) begin
            chk({tag, "_addr"}, 64'(maddr2), 64'(b0.a));
            chk({tag, "_be"}, 64'(mbe2), 64'(b0.be));
            chk({tag, "_data"}, 64'(mwdata2), 64'(b0.d));
        end
        @(posedge clk); #1;
        chk({tag, "_done"}, 64'(done2), 64'(!exp_err));
        chk({tag, "_ready"}, 64'(ready2), 64'd1);
    endtask

    initial begin
        beat_t b0, b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_write", 64'(mw), 64'd0);
        chk("rst_done_err", 64'({done, err}), 64'd0);
        chk("rst_bus", {28'(maddr), mbe, mwdata}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ack_ignored", 64'({mw, done, err}), 64'd0);

        do_store("sw_aligned", 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 1, 1, 1'b0);
        do_store("sb_lane3", 3'b000, 32'h103, 32'h000000AB, 1'b1, 1, 1, 1'b0);
        do_store("sb_mask", 3'b000, 32'h101, 32'hFFFFFF5A, 1'b1, 1, 1, 1'b0);
        do_store("sh_split", 3'b001, 32'h103, 32'h00001234, 1'b1, 2, 2, 1'b0);
        do_store("sw_split", 3'b010, 32'h102, 32'h11223344, 1'b1, 2, 2, 1'b0);
        do_store("sh_wrap", 3'b001, 32'hFFFFFFFF, 32'hCAFEBEEF, 1'b1, 2, 2, 1'b0);
        do_store("sh_mid", 3'b001, 32'h202, 32'hFFFF8765, 1'b1, 1, 1, 1'b0);
        do_store("bad_f3", 3'b011, 32'h100, 32'h0, 1'b0, 0, 0, 1'b1);

        ack = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 ack = 1'b1;
            end
        join_none
        do_store("slow_ack", 3'b010, 32'h400, 32'h0BADF00D, 1'b1, 2, 2, 1'b0);

        ack = 1'b0;
        do_store("timeout", 3'b010, 32'h300, 32'h55AA55AA, 1'b0, 4, 4, 1'b1);
        ack = 1'b1;

        st2("na_sw_mis", 3'b010, 32'h102, 32'h11223344, 1'b1);
        st2("na_sh_odd", 3'b001, 32'h101, 32'h1234, 1'b1);
        st2("na_sh_ok", 3'b001, 32'h102, 32'hABCD1234, 1'b0);

        model(3'b010, 32'h102, 32'h99887766, b0, b1);
        exp_q.push_back(b0);
        ack = 1'b0;
        @(posedge clk); #1;
        valid = 1'b1; f3 = 3'b010; addr = 32'h102; data = 32'h99887766;
        @(posedge clk); #1;
        valid = 1'b0;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("rst_mid_beat1_addr", 64'(maddr), 64'(b1.a));
        chk("rst_mid_beat1_be", 64'(mbe), 64'(b1.be));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_write", 64'(mw), 64'd0);
        chk("rst_mid_ready", 64'(ready), 64'd1);
        chk("rst_mid_pulses", 64'({done, err}), 64'd0);
        @(posedge clk); #1;
        chk("rst_mid_after", 64'({done, err, mw}), 64'd0);
        ack = 1'b1;

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
